// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: opcode/state enums, instruction field positions and data width shared by the sequencer slice.
package cpu_seq_pkg;
  localparam int DATA_W  = 8;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 4;
  localparam int RS1_MSB = 3;
  localparam int RS1_LSB = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_LDI = 2'b10, OP_HALT = 2'b11} opcode_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_FETCH = 2'b01, S_EXEC = 2'b10, S_HALT = 2'b11} state_t;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ADD/SUB (mod 256) and zero-extended LDI immediate.
module cpu_alu
  import cpu_seq_pkg::*;
(
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        imm,
  output logic [DATA_W-1:0] result
);
  always_comb
    result = op == OP_ADD ? a + b :
             op == OP_SUB ? a - b :
             op == OP_LDI ? {{(DATA_W-4){1'b0}}, imm} : '0;
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: IDLE/FETCH/EXEC/HALT instruction sequencer for a 4-register 8-bit datapath.
// Optional CPU_SEQ_RETIRE_CNT_EN adds a 16-bit retired-instruction counter output.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   pc,
  input  logic              imem_valid,
  input  logic [7:0]        imem_rdata,
  output logic [1:0]        rf_rd,
  output logic [1:0]        rf_rs1,
  output logic [1:0]        rf_rs2,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data,
  output logic              busy,
  output logic              halted
`ifdef CPU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retired
`endif
);
  state_t            state;
  logic [7:0]        instr;
  opcode_t           op;
  logic [DATA_W-1:0] alu_y;
  logic              go;
  assign op     = opcode_t'(instr[OP_MSB:OP_LSB]);
  assign go     = start && (state == S_IDLE || state == S_HALT);
  assign rf_rd  = instr[RD_MSB:RD_LSB];
  assign rf_rs1 = instr[RS1_MSB:RS1_LSB];
  assign rf_rs2 = instr[RS2_MSB:RS2_LSB];
  // Gated by rst so a reset landing on EXEC aborts the write at that same edge.
  assign rf_we    = state == S_EXEC && op != OP_HALT && !rst;
  assign rf_wd    = rf_we ? alu_y : '0;
  assign imem_req = state == S_FETCH;
  assign busy     = state == S_FETCH || state == S_EXEC;
  assign halted   = state == S_HALT;
  cpu_alu u_alu (
    .op    (op),
    .a     (rf_rs1_data),
    .b     (rf_rs2_data),
    .imm   (instr[IMM_MSB:IMM_LSB]),
    .result(alu_y)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= '0;
      instr <= '0;
    end else if (go) begin
      state <= S_FETCH;
      pc    <= '0;
    end else if (state == S_FETCH && imem_valid) begin
      instr <= imem_rdata;
      state <= S_EXEC;
    end else if (state == S_EXEC) begin
      state <= op == OP_HALT ? S_HALT : S_FETCH;
      pc    <= op == OP_HALT ? pc : pc + 1'b1;
    end
  end
`ifdef CPU_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || go) retired <= '0;
    else if (state == S_EXEC) retired <= retired + 16'd1;
  end
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed table-driven bench for cpu_sequencer with an external 4x8 register file and byte imem.
module tb_cpu_sequencer;
  logic       clk = 0;
  logic       rst = 1;
  logic       start = 0;
  logic       imem_req, imem_valid, valid_en = 1;
  logic [7:0] pc, imem_rdata;
  logic [1:0] rf_rd, rf_rs1, rf_rs2;
  logic       rf_we, busy, halted;
  logic [7:0] rf_wd, rf_rs1_data, rf_rs2_data;
  logic [7:0] mem [256];
  logic [7:0] rf [4];
  logic       pre_we = 0;
  logic [1:0] pre_a = 0;
  logic [7:0] pre_d = 0;
  logic       w_req, w_we, w_busy, w_halted;
  logic [1:0] w_pc, w_rd, w_rs1, w_rs2;
  logic [7:0] w_wd;
`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [15:0] retired, w_retired;
`endif
  int n_chk = 0;
  int n_pass = 0;
  typedef struct packed {
    logic [7:0]  ins;
    logic [31:0] regs;
    logic [1:0]  dst;
    logic [7:0]  exp;
  } vec_t;
  vec_t vt [6];
  always #5 clk = ~clk;
  assign imem_valid  = valid_en;
  assign imem_rdata  = mem[pc];
  assign rf_rs1_data = rf[rf_rs1];
  assign rf_rs2_data = rf[rf_rs2];
  always @(posedge clk) begin
    if (pre_we) rf[pre_a] <= pre_d;
    else if (rf_we) rf[rf_rd] <= rf_wd;
  end
  cpu_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .pc(pc),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_we(rf_we), .rf_wd(rf_wd),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .busy(busy), .halted(halted)
`ifdef CPU_SEQ_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );
  cpu_sequencer #(.PC_W(2)) u_wrap (
    .clk(clk), .rst(rst), .start(start), .imem_req(w_req), .pc(w_pc),
    .imem_valid(1'b1), .imem_rdata(8'h80),
    .rf_rd(w_rd), .rf_rs1(w_rs1), .rf_rs2(w_rs2), .rf_we(w_we), .rf_wd(w_wd),
    .rf_rs1_data(8'h00), .rf_rs2_data(8'h00), .busy(w_busy), .halted(w_halted)
`ifdef CPU_SEQ_RETIRE_CNT_EN
    , .retired(w_retired)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    pre_we = 1;
    pre_a  = a;
    pre_d  = d;
    tick();
    pre_we = 0;
  endtask
  task automatic go;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic run_halt(input string nm);
    int n = 0;
    while (!halted && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_halted"}, 16'(halted), 16'd1);
  endtask
  initial begin
    vt[0] = '{8'h36, 32'h00030500, 2'd3, 8'h08};
    vt[1] = '{8'h49, 32'h00030500, 2'd0, 8'hFE};
    vt[2] = '{8'h2A, 32'h00800000, 2'd2, 8'h00};
    vt[3] = '{8'h9F, 32'h0000AA00, 2'd1, 8'h0F};
    vt[4] = '{8'h70, 32'h33000007, 2'd3, 8'h00};
    vt[5] = '{8'h06, 32'h0002FF00, 2'd0, 8'h01};
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    tick();
    tick();
    chk("rst_req", 16'(imem_req), 16'd0);
    chk("rst_we", 16'(rf_we), 16'd0);
    chk("rst_wd", 16'(rf_wd), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_pc", 16'(pc), 16'd0);
    rst = 0;
    // LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT
    mem[0] = 8'h95;
    mem[1] = 8'hA3;
    mem[2] = 8'h36;
    mem[3] = 8'hC0;
    go();
    chk("prog_busy", 16'(busy), 16'd1);
    for (int k = 0; k < 7; k++) tick();
    chk("prog_not_yet_halted", 16'(halted), 16'd0);
    tick();
    chk("prog_halted", 16'(halted), 16'd1);
    chk("prog_r3", 16'(rf[3]), 16'h08);
    chk("prog_pc", 16'(pc), 16'd3);
`ifdef CPU_SEQ_RETIRE_CNT_EN
    chk("retired", retired, 16'd4);
`endif
    valid_en = 0;
    go();
    chk("restart_pc", 16'(pc), 16'd0);
    chk("restart_halted", 16'(halted), 16'd0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_req", 16'(imem_req), 16'd1);
      chk("hold_we", 16'(rf_we), 16'd0);
      chk("hold_pc", 16'(pc), 16'd0);
      start = (k == 1);
      tick();
      start = 0;
    end
    valid_en = 1;
    chk("hold_req4", 16'(imem_req), 16'd1);
    chk("hold_pc4", 16'(pc), 16'd0);
    tick();
    chk("exec_we", 16'(rf_we), 16'd1);
    chk("exec_wd", 16'(rf_wd), 16'h05);
    chk("exec_rd", 16'(rf_rd), 16'd1);
    run_halt("delay");
    preload(2'd3, 8'h55);
    go();
    for (int k = 0; k < 5; k++) tick();
    chk("abort_pre_we", 16'(rf_we), 16'd1);
    chk("abort_pre_wd", 16'(rf_wd), 16'h08);
    rst = 1;
    tick();
    rst = 0;
    chk("abort_r3", 16'(rf[3]), 16'h55);
    chk("abort_pc", 16'(pc), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_halted", 16'(halted), 16'd0);
    go();
    run_halt("rerun");
    chk("rerun_r3", 16'(rf[3]), 16'h08);
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) preload(2'(j), vt[i].regs[8*j +: 8]);
      mem[0] = vt[i].ins;
      mem[1] = 8'hC0;
      go();
      run_halt($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_result", i), 16'(rf[vt[i].dst]), 16'(vt[i].exp));
      chk($sformatf("vec%0d_pc", i), 16'(pc), 16'd1);
    end
    rst = 1;
    tick();
    rst = 0;
    go();
    chk("wrap_pc0", 16'(w_pc), 16'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("wrap_pc3", 16'(w_pc), 16'd3);
    tick();
    tick();
    chk("wrap_pc_back0", 16'(w_pc), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
